// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous word RAM behind a chipSelect/ready request handshake.
// Latency: request accepted at edge k -> ready high in the cycle after edge k+WAIT_STATES+1.
// Backpressure: busy is high while a request is in flight; chipSelect is ignored until IDLE again.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   chipSelect, writeEnable  request strobe and direction (captured in IDLE)
//   address, dataIn          word address and write data (captured in IDLE)
//   byteEnable               per-byte write mask (captured in IDLE, ignored on reads)
//   dataOut                  registered read data, 0 after reset
//   ready                    one-cycle completion pulse for reads and writes
//   busy                     high while the FSM is outside IDLE
//   addrError                out-of-range flag, valid together with ready
//
// Build option: define MEM_BOUNDS_EN to reject captured addresses >= DEPTH
// (write suppressed, read returns 0, addrError pulses with ready). Without it
// the index wraps modulo DEPTH and addrError stays 0.
// INIT_FILE is kept for interface compatibility; array preload is handled by
// the integration flow, so the array powers up with undefined contents.

module sync_ram_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      chipSelect,
    input  logic                      writeEnable,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH-1:0]     dataIn,
    input  logic [DATA_WIDTH/8-1:0]   byteEnable,
    output logic [DATA_WIDTH-1:0]     dataOut,
    output logic                      ready,
    output logic                      busy,
    output logic                      addrError
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BYTES = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Counter is loaded with WAIT_STATES-1 so WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q,   cnt_d;
    logic                  we_q,    we_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] din_q,   din_d;
    logic [BYTES-1:0]      be_q,    be_d;
    logic [DATA_WIDTH-1:0] dout_q,  dout_d;
    logic                  ready_q, ready_d;
    logic                  err_q,   err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      idx;
    logic                  oob;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  mem_wr;

    assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_BOUNDS_EN
    // One extra bit so DEPTH == 2**ADDR_WIDTH does not truncate to zero.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    assign oob = ({1'b0, addr_q} >= DEPTH_LIM);
`else
    // Upper address bits beyond the index are deliberately dropped (wrap).
    logic unused_addr;
    assign unused_addr = ^addr_q;
    assign oob = 1'b0;
`endif

    assign rd_word = mem[idx];

    // Reset in ACCESS must squash the pending write.
    assign mem_wr = (state_q == ST_ACCESS) && we_q && !oob && !reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        be_d    = be_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (chipSelect) begin
                    we_d    = writeEnable;
                    addr_d  = address;
                    din_d   = dataIn;
                    be_d    = byteEnable;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                ready_d = 1'b1;
                err_d   = oob;
                if (!we_q) begin
                    dout_d = oob ? '0 : rd_word;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            be_q    <= be_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset; only masked bytes are written.
    always_ff @(posedge clock) begin
        if (mem_wr) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= din_q[8*b +: 8];
                end
            end
        end
    end

    assign dataOut   = dout_q;
    assign ready     = ready_q;
    assign busy      = (state_q != ST_IDLE);
    assign addrError = err_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Bench for sync_ram_ctrl: edge-counting transaction model plus directed and random traffic.
// Latency: model predicts ready at acceptance edge + WAIT_STATES + 1.
// Backpressure: requests held on chipSelect until the model says the controller is idle.

module tb_sync_ram_ctrl;

    localparam int WS    = 1;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic        chipSelect;
    logic        writeEnable;
    logic [8:0]  address;
    logic [31:0] dataIn;
    logic [3:0]  byteEnable;
    logic [31:0] dataOut;
    logic        ready;
    logic        busy;
    logic        addrError;

    sync_ram_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (9),
        .DEPTH      (DEPTH),
        .WAIT_STATES(WS),
        .INIT_FILE  ("")
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .chipSelect (chipSelect),
        .writeEnable(writeEnable),
        .address    (address),
        .dataIn     (dataIn),
        .byteEnable (byteEnable),
        .dataOut    (dataOut),
        .ready      (ready),
        .busy       (busy),
        .addrError  (addrError)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          edge_n    = 0;
    int          acc_edge  = -1;
    int          rdy_edge  = -1;
    int          free_edge = 0;
    int          last_rdy  = -1;
    bit          pend      = 1'b0;
    logic        m_we;
    logic [8:0]  m_a;
    logic [31:0] m_d;
    logic [3:0]  m_be;
    logic [31:0] exp_dout  = 32'h0;
    bit          exp_err   = 1'b0;
    logic [31:0] mm [DEPTH];

    initial begin
        forever begin
            @(posedge clock);
            edge_n++;
            if (reset) begin
                pend      = 1'b0;
                exp_dout  = 32'h0;
                exp_err   = 1'b0;
                last_rdy  = -1;
                free_edge = edge_n + 1;
            end else begin
                if (pend && edge_n == rdy_edge) begin
                    bit oob;
                    int idx;
`ifdef MEM_BOUNDS_EN
                    oob = (int'(m_a) >= DEPTH);
`else
                    oob = 1'b0;
`endif
                    idx = int'(m_a) % DEPTH;
                    if (m_we) begin
                        if (!oob)
                            for (int b = 0; b < 4; b++)
                                if (m_be[b]) mm[idx][8*b +: 8] = m_d[8*b +: 8];
                    end else begin
                        exp_dout = oob ? 32'h0 : mm[idx];
                    end
                    exp_err  = oob;
                    pend     = 1'b0;
                    last_rdy = edge_n;
                end
                if (edge_n >= free_edge && chipSelect) begin
                    m_we      = writeEnable;
                    m_a       = address;
                    m_d       = dataIn;
                    m_be      = byteEnable;
                    pend      = 1'b1;
                    acc_edge  = edge_n;
                    rdy_edge  = edge_n + WS + 1;
                    free_edge = edge_n + WS + 2;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                chk("busy",    busy,      pend);
                chk("ready",   ready,     last_rdy == edge_n);
                chk("err",     addrError, (last_rdy == edge_n) && exp_err);
                chk("dout",    dataOut,   exp_dout);
                chk("overlap", busy & ready, 1'b0);
            end
        end
    end

    // ---------------- directed request helper ----------------
    task automatic do_req(input logic we, input logic [8:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd, output logic er);
        bit got;
        got = 1'b0;
        @(negedge clock);
        chipSelect  = 1'b1;
        writeEnable = we;
        address     = a;
        dataIn      = d;
        byteEnable  = be;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock);
            #1;
            if (acc_edge == edge_n) got = 1'b1;
        end
        @(negedge clock);
        chipSelect = 1'b0;
        rd = 32'h0;
        er = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept: request at addr %0h not taken within 20 cycles", a);
        end else begin
            // Third cycle counted from the acceptance edge carries ready.
            repeat (WS + 1) @(negedge clock);
            chk("lat_ready", ready, 1'b1);
            chk("lat_busy",  busy,  1'b0);
            rd = dataOut;
            er = addrError;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          rdy_cnt;

    initial begin
        reset       = 1'b1;
        chipSelect  = 1'b0;
        writeEnable = 1'b0;
        address     = '0;
        dataIn      = '0;
        byteEnable  = '0;

        @(posedge clock);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Idle after reset: all outputs at reset values.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("rst_dout", dataOut,   32'h0);
            chk("rst_rdy",  ready,     1'b0);
            chk("rst_busy", busy,      1'b0);
            chk("rst_err",  addrError, 1'b0);
        end

        do_req(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, rd, er);
        do_req(1'b0, 9'h010, 32'h0, 4'h0, rd, er);
        chk("beef", rd, 32'hDEADBEEF);

        do_req(1'b1, 9'h020, 32'h11223344, 4'hF, rd, er);
        do_req(1'b1, 9'h020, 32'hAABBCCDD, 4'b0101, rd, er);
        do_req(1'b0, 9'h020, 32'h0, 4'h0, rd, er);
        chk("bytemask", rd, 32'h11BB33DD);

        // Zero byte-enable write leaves the word alone.
        do_req(1'b1, 9'h020, 32'hFFFFFFFF, 4'h0, rd, er);
        do_req(1'b0, 9'h020, 32'h0, 4'h0, rd, er);
        chk("be_zero", rd, 32'h11BB33DD);

        for (int a = 0; a < 16; a++)
            do_req(1'b1, 9'(a), $urandom, 4'hF, rd, er);

        // chipSelect held for 10 edges: one acceptance every WS+2 edges.
        rdy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (ready) rdy_cnt++;
            chipSelect  = (i < 10);
            writeEnable = 1'b0;
            address     = 9'(i % 3);
        end
        chipSelect = 1'b0;
        chk("hold_readies", rdy_cnt, 4);

        // Reset during ACCESS aborts the second write.
        do_req(1'b1, 9'h005, 32'h00000055, 4'hF, rd, er);
        @(negedge clock);
        chipSelect  = 1'b1;
        writeEnable = 1'b1;
        address     = 9'h005;
        dataIn      = 32'h00000099;
        byteEnable  = 4'hF;
        @(posedge clock);
        #1;
        chk("abort_acc", acc_edge == edge_n, 1'b1);
        @(negedge clock);
        chipSelect = 1'b0;
        repeat (WS) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_rdy",  ready,   1'b0);
        chk("abort_busy", busy,    1'b0);
        chk("abort_dout", dataOut, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort_idle_rdy", ready, 1'b0);
        do_req(1'b0, 9'h005, 32'h0, 4'h0, rd, er);
        chk("abort_keep", rd, 32'h55);

        do_req(1'b0, 9'h105, 32'h0, 4'h0, rd, er);
`ifdef MEM_BOUNDS_EN
        chk("oob_dout", rd, 32'h0);
        chk("oob_err",  er, 1'b1);
`else
        chk("wrap_dout", rd, 32'h55);
        chk("wrap_err",  er, 1'b0);
`endif

        // Random traffic, back-to-back requests, chipSelect while busy, stray resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 149) == 0);
            if (!chipSelect || acc_edge == edge_n) begin
                chipSelect  = ($urandom_range(0, 3) != 0);
                writeEnable = 1'($urandom_range(0, 1));
                address     = 9'(($urandom_range(0, 1) << 8) | $urandom_range(0, 15));
                dataIn      = $urandom;
                byteEnable  = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clock);
        reset      = 1'b0;
        chipSelect = 1'b0;
        repeat (10) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
